// File: rtl/vmul_csa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vmul_csa_pkg
// Description : Shared helpers for the carry-save reduction tree: level
//               count, per-level vector count and pipeline rank placement.
// Revision    : 1.0 - initial release
// ============================================================================
package vmul_csa_pkg;

  localparam int CSA_MAX_LEVELS = 16;

  // Vector count after one level of 3:2 rows; leftovers pass straight through.
  function automatic int csa_next_width(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Number of CSA levels needed to reduce n vectors down to two.
  function automatic int csa_level_count(input int n);
    int w;
    int lvl;
    w   = n;
    lvl = 0;
    for (int i = 0; i < CSA_MAX_LEVELS; i++) begin
      if (w > 2) begin
        w   = csa_next_width(w);
        lvl = lvl + 1;
      end
    end
    return lvl;
  endfunction

  // Number of vectors present at the output of level lvl (level 0 = operands).
  function automatic int csa_width_at_level(input int n, input int lvl);
    int w;
    w = n;
    for (int i = 0; i < CSA_MAX_LEVELS; i++) begin
      if (i < lvl) begin
        w = csa_next_width(w);
      end
    end
    return w;
  endfunction

  // CSA level after which intermediate rank r (1 .. stages-1) is placed.
  function automatic int rank_level(input int r, input int levels, input int stages);
    return (r * levels) / stages;
  endfunction

  // Zero-based rank index registered at level lvl, or -1 if that level is
  // purely combinational.
  function automatic int rank_for_level(input int lvl, input int levels, input int stages);
    int k;
    k = -1;
    for (int r = 1; r <= CSA_MAX_LEVELS + 1; r++) begin
      if (r < stages && rank_level(r, levels, stages) == lvl) begin
        k = r - 1;
      end
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
// Module      : csa_row
// Description : One WORDLEN-wide 3:2 compressor row built from a bitwise
//               full-adder array. The carry vector is pre-shifted left by one
//               with its MSB dropped (modulo 2^WORDLEN arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module csa_row
  import vmul_csa_pkg::*;
#(
  parameter int WORDLEN = 32
) (
  input  logic [WORDLEN-1:0] a_i,
  input  logic [WORDLEN-1:0] b_i,
  input  logic [WORDLEN-1:0] c_i,
  output logic [WORDLEN-1:0] sum_o,
  output logic [WORDLEN-1:0] carry_o
);

  assign carry_o[0] = 1'b0;

  for (genvar b = 0; b < WORDLEN; b++) begin : g_fa
    assign sum_o[b] = a_i[b] ^ b_i[b] ^ c_i[b];
    // The top bit's carry would land at weight 2^WORDLEN and is discarded.
    if (b < WORDLEN - 1) begin : g_cy
      assign carry_o[b+1] = (a_i[b] & b_i[b]) | (a_i[b] & c_i[b]) | (b_i[b] & c_i[b]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/csa_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csa_tree_pipe
// Description : Pipelined N-operand carry-save reduction tree with final
//               carry-propagate add, per-operand mask, sideband tag and
//               valid/ready flow control with bubble collapsing.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_tree_pipe
  import vmul_csa_pkg::*;
#(
  parameter int WORDLEN     = 32,
  parameter int NUM_IN      = 18,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WORDLEN-1:0] in_data,
  input  logic [NUM_IN-1:0]         in_mask,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORDLEN-1:0]        out_sum,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int c_levels = csa_level_count(NUM_IN);
  localparam int c_last   = PIPE_STAGES - 1;

  // comb_v[l] : vectors produced by level l (level 0 = masked operands)
  // src_v[l]  : what level l+1 consumes - comb_v[l] or a rank register
  logic [WORDLEN-1:0] comb_v [0:c_levels][0:NUM_IN-1];
  logic [WORDLEN-1:0] src_v  [0:c_levels][0:NUM_IN-1];

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] vld_d;
  logic [PIPE_STAGES-1:0] adv;
  logic [TAG_W-1:0]       tag_q [0:PIPE_STAGES-1];
  logic [TAG_W-1:0]       tag_d [0:PIPE_STAGES-1];
  logic [WORDLEN-1:0]     sum_q;
  logic [WORDLEN-1:0]     sum_d;
  logic [WORDLEN-1:0]     cpa_sum;
  logic                   in_fire;

  // ---------------------------------------------------------------------
  // Flow control: a rank advances when empty or when its successor does.
  // ---------------------------------------------------------------------
  assign adv[c_last] = !vld_q[c_last] | out_ready;

  for (genvar k = 0; k < c_last; k++) begin : g_adv
    assign adv[k] = !vld_q[k] | adv[k+1];
  end

  assign in_ready = adv[0];
  assign in_fire  = in_valid & adv[0];

  // ---------------------------------------------------------------------
  // Level 0: masked operands.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_IN; i++) begin : g_mask
    assign comb_v[0][i] = in_mask[i] ? in_data[i*WORDLEN +: WORDLEN] : '0;
  end

  // ---------------------------------------------------------------------
  // CSA levels 1..L: groups of three go through a row, leftovers pass.
  // ---------------------------------------------------------------------
  for (genvar l = 1; l <= c_levels; l++) begin : g_lvl
    localparam int c_np = csa_width_at_level(NUM_IN, l - 1);
    localparam int c_nr = c_np / 3;
    localparam int c_nl = c_np % 3;
    localparam int c_nw = csa_width_at_level(NUM_IN, l);

    for (genvar j = 0; j < c_nr; j++) begin : g_row
      csa_row #(
        .WORDLEN (WORDLEN)
      ) u_row (
        .a_i     (src_v[l-1][3*j]),
        .b_i     (src_v[l-1][3*j+1]),
        .c_i     (src_v[l-1][3*j+2]),
        .sum_o   (comb_v[l][2*j]),
        .carry_o (comb_v[l][2*j+1])
      );
    end

    for (genvar j = 0; j < c_nl; j++) begin : g_pass
      assign comb_v[l][2*c_nr+j] = src_v[l-1][3*c_nr+j];
    end

    for (genvar j = c_nw; j < NUM_IN; j++) begin : g_zero
      assign comb_v[l][j] = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Rank placement: a level either feeds the next one directly or through
  // the data register of the rank that sits after it.
  // ---------------------------------------------------------------------
  for (genvar l = 0; l <= c_levels; l++) begin : g_src
    localparam int c_rk = rank_for_level(l, c_levels, PIPE_STAGES);
    localparam int c_nw = csa_width_at_level(NUM_IN, l);

    if (c_rk < 0) begin : g_wire
      for (genvar j = 0; j < NUM_IN; j++) begin : g_bit
        assign src_v[l][j] = comb_v[l][j];
      end
    end else begin : g_reg
      logic [WORDLEN-1:0] data_q [0:c_nw-1];

      // Intermediate rank data: load on advance, hold otherwise.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int j = 0; j < c_nw; j++) data_q[j] <= '0;
        end else if (adv[c_rk]) begin
          for (int j = 0; j < c_nw; j++) data_q[j] <= comb_v[l][j];
        end
      end

      for (genvar j = 0; j < NUM_IN; j++) begin : g_bit
        if (j < c_nw) begin : g_live
          assign src_v[l][j] = data_q[j];
        end else begin : g_dead
          assign src_v[l][j] = comb_v[l][j];
        end
      end
    end
  end

  // Final carry-propagate add of the two surviving vectors.
  assign cpa_sum = src_v[c_levels][0] + src_v[c_levels][1];

  // Next state for every rank's valid/tag and the output sum register.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    sum_d = sum_q;
    if (adv[0]) begin
      vld_d[0] = in_fire;
      tag_d[0] = in_tag;
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
    if (adv[c_last]) begin
      sum_d = cpa_sum;
    end
  end

  // Valid, tag and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      sum_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) tag_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      sum_q <= sum_d;
      for (int k = 0; k < PIPE_STAGES; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign out_valid = vld_q[c_last];
  assign out_sum   = sum_q;
  assign out_tag   = tag_q[c_last];

endmodule
`default_nettype wire

// File: tb/tb_csa_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_tree_pipe
// Description : Self-checking bench for csa_tree_pipe: directed sums,
//               streaming, back-pressure, mid-flight reset and a sweep of
//               operand counts and pipeline depths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_tree_pipe;

  localparam int c_w   = 8;
  localparam int c_ni  = 18;
  localparam int c_ps  = 3;
  localparam int c_nsw = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [c_ni*c_w-1:0]  in_data;
  logic [c_ni-1:0]      in_mask;
  logic [7:0]           in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [c_w-1:0]       out_sum;
  logic [7:0]           out_tag;

  logic [33*c_w-1:0]    sw_data;
  logic [32:0]          sw_mask;
  logic [7:0]           sw_tag;
  logic                 sw_in_valid;
  logic [c_nsw-1:0]     sw_rdy;
  logic [c_nsw-1:0]     sw_ov;
  logic [7:0]           sw_sum  [c_nsw];
  logic [7:0]           sw_otag [c_nsw];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_sum [$];
  logic [7:0] q_tag [$];

  always #5 clk = ~clk;

  csa_tree_pipe #(
    .WORDLEN     (c_w),
    .NUM_IN      (c_ni),
    .PIPE_STAGES (c_ps),
    .TAG_W       (8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_tag   (out_tag)
  );

  // Sweep configurations: NUM_IN in {3,4,5,33} with PIPE_STAGES 1 and L+1.
  function automatic int sw_ni(input int g);
    case (g)
      0, 1:    return 3;
      2, 3:    return 4;
      4, 5:    return 5;
      default: return 33;
    endcase
  endfunction

  function automatic int sw_ps(input int g);
    case (g)
      1:       return 2;
      3:       return 3;
      5:       return 4;
      7:       return 9;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < c_nsw; g++) begin : g_sw
    localparam int c_gni = sw_ni(g);
    localparam int c_gps = sw_ps(g);
    csa_tree_pipe #(
      .WORDLEN     (c_w),
      .NUM_IN      (c_gni),
      .PIPE_STAGES (c_gps),
      .TAG_W       (8)
    ) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_rdy[g]),
      .in_data   (sw_data[c_gni*c_w-1:0]),
      .in_mask   (sw_mask[c_gni-1:0]),
      .in_tag    (sw_tag),
      .out_valid (sw_ov[g]),
      .out_ready (1'b1),
      .out_sum   (sw_sum[g]),
      .out_tag   (sw_otag[g])
    );
  end

  // Reference: plain sum of included operands, wrapped to 8 bits.
  function automatic logic [7:0] ref_sum(input logic [33*c_w-1:0] d, input logic [32:0] m, input int n);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (m[i]) acc = acc + d[i*c_w +: c_w];
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] main_ref;
    return ref_sum({120'b0, in_data}, {15'b0, in_mask}, c_ni);
  endfunction

  // Advance one clock; report what the main DUT transferred at that edge.
  task automatic tick(output bit acc, output bit emit, output logic [7:0] esum, output logic [7:0] etag);
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    esum = out_sum;
    etag = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_main;
    for (int i = 0; i < c_ni; i++) in_data[i*c_w +: c_w] = 8'($urandom);
    in_mask = 18'($urandom);
    in_tag  = 8'($urandom);
  endtask

  task automatic test_reset;
    bit a, e; logic [7:0] s, t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sw_in_valid = 1'b0;
    in_data = '0; in_mask = '0; in_tag = '0;
    sw_data = '0; sw_mask = '0; sw_tag = '0;
    tick(a, e, s, t);
    tick(a, e, s, t);
    rst_n = 1'b1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_sum !== 8'h00) begin n_fail++; $display("FAIL reset_out_sum got %h want 00", out_sum); end
    n_tests++; if (out_tag !== 8'h00) begin n_fail++; $display("FAIL reset_out_tag got %h want 00", out_tag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    bit a, e; logic [7:0] s, t;
    logic [7:0] exp_sum, exp_tag;
    int cnt, tries;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin for (int i = 0; i < c_ni; i++) in_data[i*c_w +: c_w] = 8'h01;
                 in_mask = '1; exp_tag = 8'h5A; exp_sum = 8'h12; end
        1: begin for (int i = 0; i < c_ni; i++) in_data[i*c_w +: c_w] = 8'hFF;
                 in_mask = '1; exp_tag = 8'hA5; exp_sum = 8'hEE; end
        2: begin for (int i = 0; i < c_ni; i++) in_data[i*c_w +: c_w] = 8'(i + 1);
                 in_mask = 18'h00005; exp_tag = 8'h11; exp_sum = 8'h04; end
        default: begin rand_main(); in_mask = '0; exp_tag = 8'h3C; exp_sum = 8'h00; end
      endcase
      in_tag = exp_tag; out_ready = 1'b1; in_valid = 1'b1;
      tries = 0; a = 1'b0;
      while (!a && tries < 10) begin tick(a, e, s, t); tries++; end
      in_valid = 1'b0;
      n_tests++; if (!a) begin n_fail++; $display("FAIL directed%0d_accept got none want accept", k); end
      cnt = 1;
      while (out_valid !== 1'b1 && cnt < 20) begin tick(a, e, s, t); cnt++; end
      n_tests++; if (cnt !== c_ps) begin n_fail++; $display("FAIL directed%0d_latency got %0d want %0d", k, cnt, c_ps); end
      n_tests++; if (out_sum !== exp_sum) begin n_fail++; $display("FAIL directed%0d_sum got %h want %h", k, out_sum, exp_sum); end
      n_tests++; if (out_tag !== exp_tag) begin n_fail++; $display("FAIL directed%0d_tag got %h want %h", k, out_tag, exp_tag); end
      tick(a, e, s, t);
    end
  endtask

  task automatic test_back_to_back;
    bit a, e; logic [7:0] s, t;
    logic [7:0] es, et;
    int sent, rcv, first_c, last_c;
    sent = 0; rcv = 0; first_c = -1; last_c = -1;
    q_sum.delete(); q_tag.delete();
    out_ready = 1'b1;
    rand_main(); in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent < 20) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc %0d got %b want 1", cyc, in_ready); end
      end
      tick(a, e, s, t);
      if (a) begin
        q_sum.push_back(main_ref()); q_tag.push_back(in_tag);
        sent++;
        if (sent < 20) rand_main(); else in_valid = 1'b0;
      end
      if (e) begin
        if (q_sum.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL stream_extra got sum %h want no result", s);
        end else begin
          es = q_sum.pop_front(); et = q_tag.pop_front();
          n_tests++; if (s !== es || t !== et) begin n_fail++; $display("FAIL stream_data got %h/%h want %h/%h", s, t, es, et); end
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc; rcv++;
      end
    end
    n_tests++; if (rcv !== 20) begin n_fail++; $display("FAIL stream_count got %0d want 20", rcv); end
    n_tests++; if (last_c - first_c !== 19) begin n_fail++; $display("FAIL stream_rate got span %0d want 19", last_c - first_c); end
  endtask

  task automatic test_backpressure;
    bit a, e; logic [7:0] s, t;
    logic [7:0] es, et, hs, ht;
    bit held;
    int accs, rcv;
    accs = 0; rcv = 0; held = 1'b0; hs = '0; ht = '0;
    q_sum.delete(); q_tag.delete();
    out_ready = 1'b0;
    rand_main(); in_valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick(a, e, s, t);
      if (a) begin
        q_sum.push_back(main_ref()); q_tag.push_back(in_tag);
        accs++; rand_main();
      end
      if (out_valid === 1'b1) begin
        if (!held) begin held = 1'b1; hs = out_sum; ht = out_tag; end
        else begin
          n_tests++; if (out_sum !== hs || out_tag !== ht) begin n_fail++; $display("FAIL bp_stable got %h/%h want %h/%h", out_sum, out_tag, hs, ht); end
        end
      end
    end
    n_tests++; if (accs !== c_ps) begin n_fail++; $display("FAIL bp_accepts got %0d want %0d", accs, c_ps); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick(a, e, s, t);
      if (e) begin
        rcv++;
        if (q_sum.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL bp_extra got sum %h want no result", s);
        end else begin
          es = q_sum.pop_front(); et = q_tag.pop_front();
          n_tests++; if (s !== es || t !== et) begin n_fail++; $display("FAIL bp_drain got %h/%h want %h/%h", s, t, es, et); end
        end
      end
    end
    n_tests++; if (rcv !== c_ps) begin n_fail++; $display("FAIL bp_drain_count got %0d want %0d", rcv, c_ps); end
  endtask

  task automatic test_reset_midflight;
    bit a, e; logic [7:0] s, t;
    int accs, emits, tries;
    accs = 0; emits = 0; tries = 0;
    out_ready = 1'b0;
    rand_main(); in_valid = 1'b1;
    while (accs < 3 && tries < 10) begin
      tick(a, e, s, t); tries++;
      if (a) begin accs++; rand_main(); end
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick(a, e, s, t);
    rst_n = 1'b1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_sum !== 8'h00) begin n_fail++; $display("FAIL rstmid_out_sum got %h want 00", out_sum); end
    n_tests++; if (out_tag !== 8'h00) begin n_fail++; $display("FAIL rstmid_out_tag got %h want 00", out_tag); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick(a, e, s, t);
      if (e) emits++;
    end
    n_tests++; if (emits !== 0) begin n_fail++; $display("FAIL rstmid_ghost got %0d results want 0", emits); end
  endtask

  task automatic test_sweep;
    bit a, e; logic [7:0] s, t;
    int lat [c_nsw];
    logic [7:0] gs [c_nsw];
    logic [7:0] gt [c_nsw];
    logic [7:0] es;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 33; i++) sw_data[i*c_w +: c_w] = 8'($urandom);
      sw_mask = {1'($urandom), 32'($urandom)};
      if (rep == 0) sw_mask = '1;
      sw_tag = 8'($urandom);
      n_tests++; if (sw_rdy !== '1) begin n_fail++; $display("FAIL sweep_ready got %b want all ones", sw_rdy); end
      sw_in_valid = 1'b1;
      tick(a, e, s, t);
      sw_in_valid = 1'b0;
      for (int g = 0; g < c_nsw; g++) begin lat[g] = 0; gs[g] = '0; gt[g] = '0; end
      for (int cnt = 1; cnt <= 12; cnt++) begin
        for (int g = 0; g < c_nsw; g++) begin
          if (lat[g] == 0 && sw_ov[g] === 1'b1) begin lat[g] = cnt; gs[g] = sw_sum[g]; gt[g] = sw_otag[g]; end
        end
        tick(a, e, s, t);
      end
      for (int g = 0; g < c_nsw; g++) begin
        es = ref_sum(sw_data, sw_mask, sw_ni(g));
        n_tests++; if (lat[g] !== sw_ps(g)) begin n_fail++; $display("FAIL sweep_latency ni%0d ps%0d got %0d want %0d", sw_ni(g), sw_ps(g), lat[g], sw_ps(g)); end
        n_tests++; if (gs[g] !== es || gt[g] !== sw_tag) begin n_fail++; $display("FAIL sweep_sum ni%0d ps%0d got %h/%h want %h/%h", sw_ni(g), sw_ps(g), gs[g], gt[g], es, sw_tag); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
